// File: rtl/ex_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// EX_MDU_MADD_EN enables the MADD/MSUB multiply-accumulate ops.
package ex_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MADD  = 3'd6,
        MDU_MSUB  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    function automatic logic is_multi(input logic [2:0] op);
        logic r;
        case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: r = 1'b1;
`ifdef EX_MDU_MADD_EN
            MDU_MADD, MDU_MSUB:                     r = 1'b1;
`endif
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generation for multiply, divide and accumulate.
// MADD/MSUB accumulate path exists only when EX_MDU_MADD_EN is defined.
module mdu_arith
    import ex_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0] a_sx, b_sx, a_zx, b_zx;
    logic [W2-1:0] prod_s, prod_u;
    logic [WIDTH-1:0] q_s, r_s, q_u, r_u;
    logic signed [WIDTH-1:0] a_s, b_s_safe;
    logic [WIDTH-1:0] b_u_safe;
    logic div_zero, div_ovf;

    // Low 2*WIDTH bits of the product do not depend on signedness once
    // the operands are extended appropriately.
    assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
    assign a_zx   = {{WIDTH{1'b0}}, a};
    assign b_zx   = {{WIDTH{1'b0}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;

    assign div_zero = (b == '0);
    assign div_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

    // Substitute a harmless divisor for the special cases so the divider
    // itself never sees /0 or MIN/-1; results are overridden below.
    assign a_s      = $signed(a);
    assign b_s_safe = (div_zero || div_ovf) ? WIDTH'(1) : $signed(b);
    assign b_u_safe = div_zero ? WIDTH'(1) : b;
    assign q_s      = WIDTH'(a_s / b_s_safe);
    assign r_s      = WIDTH'(a_s % b_s_safe);
    assign q_u      = a / b_u_safe;
    assign r_u      = a % b_u_safe;

`ifdef EX_MDU_MADD_EN
    logic [W2-1:0] acc_add, acc_sub;
    assign acc_add = {hi, lo} + prod_s;
    assign acc_sub = {hi, lo} - prod_s;
`endif

    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV: begin
                if (div_zero) begin
                    res_hi = a;
                    res_lo = '1;
                end else if (div_ovf) begin
                    res_hi = '0;
                    res_lo = a;
                end else begin
                    res_hi = r_s;
                    res_lo = q_s;
                end
            end
            MDU_DIVU: begin
                if (div_zero) begin
                    res_hi = a;
                    res_lo = '1;
                end else begin
                    res_hi = r_u;
                    res_lo = q_u;
                end
            end
`ifdef EX_MDU_MADD_EN
            MDU_MADD:  {res_hi, res_lo} = acc_add;
            MDU_MSUB:  {res_hi, res_lo} = acc_sub;
`endif
            default: begin
                res_hi = hi;
                res_lo = lo;
            end
        endcase
    end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: IDLE/RUN sequencer with HI/LO registers.
// Define EX_MDU_MADD_EN to enable MADD/MSUB; otherwise ops 6/7 are no-ops.
module ex_mdu
    import ex_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [4:0] MUL_CNT = 5'(MUL_LAT);
    localparam logic [4:0] DIV_CNT = 5'(DIV_LAT);

    mdu_state_e       state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] arith_hi, arith_lo;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (op),
        .a      (a),
        .b      (b),
        .hi     (hi_q),
        .lo     (lo_q),
        .res_hi (arith_hi),
        .res_lo (arith_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == MDU_MTHI) begin
                        hi_d = a;
                    end else if (op == MDU_MTLO) begin
                        lo_d = a;
                    end else if (is_multi(op)) begin
                        // Result is captured now; HI/LO stay architecturally
                        // stable until the countdown expires.
                        res_hi_d = arith_hi;
                        res_lo_d = arith_lo;
                        cnt_d    = is_div(op) ? DIV_CNT : MUL_CNT;
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    hi_d    = res_hi_q;
                    lo_d    = res_lo_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Directed self-checking bench for ex_mdu with hand-computed HI/LO results.
module tb_ex_mdu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_pass   = 0;

    ex_mdu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    endtask

    // Issue one op, then count busy cycles (sampled on negedges) until idle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int nb, output logic dn);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 64) begin
            nb++;
            @(negedge clk);
        end
        dn = done;
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d done=%b", o, x, y, hi, lo, nb, dn);
    endtask

    int   nb;
    logic dn;
    int   cyc;
    logic done_seen;

    initial begin
        #2;
        chk("reset_hi", 64'(hi), 64'h0);
        chk("reset_lo", 64'(lo), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);

        // First start accepted on the first edge after reset release
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1; op = 3'd5; a = 32'h55;
        @(negedge clk);
        start = 1'b0;
        chk("first_start_lo", 64'(lo), 64'h55);
        $display("first start MTLO 55 -> lo=%h", lo);

        run_op(3'd0, 32'hFFFFFFFE, 32'd3, nb, dn);
        chk("mult_busy", 64'(nb), 64'd5);
        chk("mult_done", 64'(dn), 64'h1);
        chk("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        @(negedge clk);
        chk("mult_done_width", 64'(done), 64'h0);

        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, nb, dn);
        chk("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

        run_op(3'd2, 32'hFFFFFFF9, 32'd2, nb, dn);
        chk("div_busy", 64'(nb), 64'd10);
        chk("div_done", 64'(dn), 64'h1);
        chk("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

        run_op(3'd3, 32'd7, 32'd0, nb, dn);
        chk("divu0_busy", 64'(nb), 64'd10);
        chk("divu0_hilo", {hi, lo}, 64'h00000007_FFFFFFFF);

        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, nb, dn);
        chk("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);

        run_op(3'd2, 32'd7, 32'hFFFFFFFE, nb, dn);
        chk("div_negdiv_hilo", {hi, lo}, 64'h00000001_FFFFFFFD);

        run_op(3'd3, 32'd100, 32'd7, nb, dn);
        chk("divu_hilo", {hi, lo}, 64'h00000002_0000000E);

        run_op(3'd5, 32'h1234, 32'd0, nb, dn);
        chk("mtlo_lo", 64'(lo), 64'h1234);
        chk("mtlo_busy", 64'(nb), 64'd0);
        chk("mtlo_done", 64'(dn), 64'h0);
        chk("mtlo_hi_kept", 64'(hi), 64'h2);

        run_op(3'd4, 32'hABCD, 32'd0, nb, dn);
        chk("mthi_hilo", {hi, lo}, 64'h0000ABCD_00001234);

        // Second MULT during busy must be dropped; HI/LO frozen while running
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
        @(negedge clk);
        a = 32'd100; b = 32'd100;
        nb = 0;
        while (busy === 1'b1 && nb < 64) begin
            nb++;
            if (nb == 2) begin
                start = 1'b0;
                chk("run_hilo_frozen", {hi, lo}, 64'h0000ABCD_00001234);
            end
            @(negedge clk);
        end
        start = 1'b0;
        $display("MULT 6*7 with MULT 100*100 during busy -> hi=%h lo=%h busy_cycles=%0d", hi, lo, nb);
        chk("ignore_busy", 64'(nb), 64'd5);
        chk("ignore_hilo", {hi, lo}, 64'h00000000_0000002A);
        @(negedge clk);
        chk("ignore_no_restart", 64'(busy), 64'h0);

        // Reset in cycle 3 of a DIV aborts it
        run_op(3'd5, 32'h77, 32'd0, nb, dn);
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_hilo", {hi, lo}, 64'h0);
        chk("abort_busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
        end
        $display("DIV 100/3 aborted by reset -> hi=%h lo=%h", hi, lo);
        chk("abort_no_done", 64'(done_seen), 64'h0);
        chk("abort_hilo_after", {hi, lo}, 64'h0);

        run_op(3'd5, 32'd1, 32'd0, nb, dn);
        run_op(3'd6, 32'd2, 32'd3, nb, dn);
`ifdef EX_MDU_MADD_EN
        chk("madd_busy", 64'(nb), 64'd5);
        chk("madd_hilo", {hi, lo}, 64'h00000000_00000007);
        run_op(3'd7, 32'd2, 32'd3, nb, dn);
        chk("msub_hilo", {hi, lo}, 64'h00000000_00000001);
        run_op(3'd7, 32'd2, 32'd1, nb, dn);
        chk("msub_wrap", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
        run_op(3'd6, 32'hFFFFFFFF, 32'd1, nb, dn);
        chk("madd_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
`else
        chk("madd_off_busy", 64'(nb), 64'd0);
        chk("madd_off_done", 64'(dn), 64'h0);
        chk("madd_off_hilo", {hi, lo}, 64'h00000000_00000001);
        run_op(3'd7, 32'd2, 32'd3, nb, dn);
        chk("msub_off_hilo", {hi, lo}, 64'h00000000_00000001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
